// File: rtl/bn_pkg.sv
// Shared constants for the batch-norm calibrator: gain codes, FSM states and gain lookup helpers.
package bn_pkg;

    localparam logic [3:0] BN_CODE_Q025 = 4'b1000;
    localparam logic [3:0] BN_CODE_Q050 = 4'b0001;
    localparam logic [3:0] BN_CODE_Q075 = 4'b1001;
    localparam logic [3:0] BN_CODE_X1   = 4'b0100;
    localparam logic [3:0] BN_CODE_X15  = 4'b0101;
    localparam logic [3:0] BN_CODE_X2   = 4'b0010;
    localparam logic [3:0] BN_CODE_X225 = 4'b1010;
    localparam logic [3:0] BN_CODE_X3   = 4'b0110;
    localparam logic [3:0] BN_CODE_X4   = 4'b1100;
    localparam logic [3:0] BN_CODE_X45  = 4'b1101;
    localparam logic [3:0] BN_CODE_X6   = 4'b1110;
    localparam logic [3:0] BN_CODE_X8   = 4'b0011;
    localparam logic [3:0] BN_CODE_UNITY = BN_CODE_X1;

    localparam int BN_NUM_GAINS = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_COMPUTE,
        ST_DONE
    } bn_state_t;

    // Gains are indexed in ascending order so the highest fitting index wins.
    function automatic logic [3:0] bn_gain_code(input int idx);
        case (idx)
            0:       return BN_CODE_Q025;
            1:       return BN_CODE_Q050;
            2:       return BN_CODE_Q075;
            3:       return BN_CODE_X1;
            4:       return BN_CODE_X15;
            5:       return BN_CODE_X2;
            6:       return BN_CODE_X225;
            7:       return BN_CODE_X3;
            8:       return BN_CODE_X4;
            9:       return BN_CODE_X45;
            10:      return BN_CODE_X6;
            default: return BN_CODE_X8;
        endcase
    endfunction

    // Gain expressed in quarters, so every gain is an integer multiplier.
    function automatic logic [5:0] bn_gain_quarters(input int idx);
        case (idx)
            0:       return 6'd1;
            1:       return 6'd2;
            2:       return 6'd3;
            3:       return 6'd4;
            4:       return 6'd6;
            5:       return 6'd8;
            6:       return 6'd9;
            7:       return 6'd12;
            8:       return 6'd16;
            9:       return 6'd18;
            10:      return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/bn_factor_select.sv
// Combinational peak-to-gain-code selection: largest gain whose product with peak stays in range.
module bn_factor_select
    import bn_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] peak,
    output logic [3:0]       code
);

    localparam int PW = WIDTH + 6;
    // Compare q*peak against 4*(2^(WIDTH-1)-1) to stay in integer quarters.
    localparam logic [PW-1:0] LIMIT = {5'b0, {(WIDTH-1){1'b1}}, 2'b00};

    logic [BN_NUM_GAINS-1:0] fits;

    for (genvar gi = 0; gi < BN_NUM_GAINS; gi++) begin : g_gain
        localparam logic [5:0] QV = bn_gain_quarters(gi);
        logic [PW-1:0] prod;

        always_comb begin
            prod = '0;
            for (int b = 0; b < 6; b++) begin
                if (QV[b]) begin
                    prod = prod + ({6'b0, peak} << b);
                end
            end
        end

        assign fits[gi] = (prod <= LIMIT);
    end

    always_comb begin
        code = BN_CODE_Q025;
        for (int i = 0; i < BN_NUM_GAINS; i++) begin
            if (fits[i]) begin
                code = bn_gain_code(i);
            end
        end
    end

endmodule

// File: rtl/bn_calibrator.sv
// Batch-norm calibrator: collects 2^LOG2_SAMPLES samples, then derives gain code and offset.
// Define BN_CALIB_ADDEND_EN to build the sum accumulator and the BN_addend computation.
module bn_calibrator
    import bn_pkg::*;
#(
    parameter int WIDTH        = 6,
    parameter int ADDEND_WIDTH = WIDTH - 2,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    z_valid,
    input  logic [WIDTH-1:0]        z,
    output logic                    busy,
    output logic                    done,
    output logic                    params_valid,
    output logic [3:0]              BN_factor,
    output logic [ADDEND_WIDTH-1:0] BN_addend
);

    bn_state_t state_reg, state_next;

    logic [LOG2_SAMPLES-1:0] count_reg;
    logic [WIDTH-1:0]        peak_reg;
    logic [WIDTH-1:0]        z_abs;
    logic [3:0]              factor_reg;
    logic [3:0]              sel_code;
    logic                    valid_reg;
    logic                    clear_acc;
    logic                    accept;
    logic                    load;

    // Two's-complement magnitude in WIDTH unsigned bits keeps |-2^(WIDTH-1)| exact.
    assign z_abs = z[WIDTH-1] ? (~z + 1'b1) : z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear_acc  = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear_acc  = 1'b1;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (start) begin
                    clear_acc = 1'b1;
                end else if (z_valid) begin
                    accept = 1'b1;
                    if (&count_reg) begin
                        state_next = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                load       = 1'b1;
                state_next = ST_DONE;
            end
            default: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    bn_factor_select #(
        .WIDTH (WIDTH)
    ) u_factor_select (
        .peak (peak_reg),
        .code (sel_code)
    );

    // params_valid rises with the load so it is already high during the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= '0;
            peak_reg   <= '0;
            factor_reg <= BN_CODE_UNITY;
            valid_reg  <= 1'b0;
        end else begin
            if (clear_acc) begin
                count_reg <= '0;
                peak_reg  <= '0;
            end else if (accept) begin
                count_reg <= count_reg + 1'b1;
                if (z_abs > peak_reg) begin
                    peak_reg <= z_abs;
                end
            end
            if (load) begin
                factor_reg <= sel_code;
                valid_reg  <= 1'b1;
            end
        end
    end

    assign BN_factor    = factor_reg;
    assign params_valid = valid_reg;

`ifdef BN_CALIB_ADDEND_EN
    localparam int SW = WIDTH + LOG2_SAMPLES;
    localparam logic signed [SW-1:0] A_MAX = {{(SW-ADDEND_WIDTH+1){1'b0}}, {(ADDEND_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] A_MIN = ~A_MAX;

    logic signed [SW-1:0]    sum_reg;
    logic signed [SW-1:0]    mean;
    logic signed [SW-1:0]    neg_mean;
    logic [ADDEND_WIDTH-1:0] addend_reg;
    logic [ADDEND_WIDTH-1:0] addend_sat;

    always_comb begin
        mean     = sum_reg >>> LOG2_SAMPLES;
        neg_mean = -mean;
        if (neg_mean > A_MAX) begin
            addend_sat = A_MAX[ADDEND_WIDTH-1:0];
        end else if (neg_mean < A_MIN) begin
            addend_sat = A_MIN[ADDEND_WIDTH-1:0];
        end else begin
            addend_sat = neg_mean[ADDEND_WIDTH-1:0];
        end
    end

    // At gain 8 the window is essentially silent, so no offset is applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg    <= '0;
            addend_reg <= '0;
        end else begin
            if (clear_acc) begin
                sum_reg <= '0;
            end else if (accept) begin
                sum_reg <= sum_reg + {{LOG2_SAMPLES{z[WIDTH-1]}}, z};
            end
            if (load) begin
                addend_reg <= (sel_code == BN_CODE_X8) ? '0 : addend_sat;
            end
        end
    end

    assign BN_addend = addend_reg;
`else
    assign BN_addend = '0;
`endif

endmodule

// File: tb/tb_bn_calibrator.sv
// Scoreboard bench for bn_calibrator: directed calibration windows, monitor checks each done pulse.
module tb_bn_calibrator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       z_valid = 1'b0;
    logic [5:0] z = 6'd0;
    logic       busy;
    logic       done;
    logic       params_valid;
    logic [3:0] BN_factor;
    logic [3:0] BN_addend;

    typedef struct {
        logic [3:0] f;
        logic [3:0] a;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    bn_calibrator #(
        .WIDTH        (6),
        .ADDEND_WIDTH (4),
        .LOG2_SAMPLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .z_valid      (z_valid),
        .z            (z),
        .busy         (busy),
        .done         (done),
        .params_valid (params_valid),
        .BN_factor    (BN_factor),
        .BN_addend    (BN_addend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_add(input logic [3:0] a);
`ifdef BN_CALIB_ADDEND_EN
        return a;
`else
        return 4'd0;
`endif
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
                e = sb.pop_front();
                check({e.name, "_factor"}, 32'(BN_factor), 32'(e.f));
                check({e.name, "_addend"}, 32'(BN_addend), 32'(e.a));
                check({e.name, "_pvalid"}, 32'(params_valid), 32'd1);
                $display("window %s: factor=%b addend=%b", e.name, BN_factor, BN_addend);
            end
        end
    end

    task automatic push(input string name, input logic [3:0] f, input logic [3:0] a);
        exp_t e;
        e.name = name;
        e.f    = f;
        e.a    = exp_add(a);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input logic [5:0] v);
        z_valid = 1'b1;
        z       = v;
        repeat (n) tick();
        z_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        check("done_count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pvalid", 32'(params_valid), 32'd0);
        check("rst_factor", 32'(BN_factor), 32'b0100);
        check("rst_addend", 32'(BN_addend), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // z=5: peak 5 -> gain 6; mean 5 -> addend -5
        push("z5", 4'b1110, 4'b1011);
        do_start();
        check("accum_busy", 32'(busy), 32'd1);
        send(16, 6'd5);
        check("compute_done_low", 32'(done), 32'd0);
        check("compute_busy", 32'(busy), 32'd1);
        check("compute_factor_hold", 32'(BN_factor), 32'b0100);
        tick();
        check("done_pulse", 32'(done), 32'd1);
        wait_done(1);
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_done", 32'(done), 32'd0);
        check("factor_hold", 32'(BN_factor), 32'b1110);

        // z=-12 with a gap in z_valid: gain 2.25, addend saturates at +7
        push("zm12", 4'b1010, 4'b0111);
        do_start();
        send(8, 6'b110100);
        repeat (3) tick();
        check("gap_busy", 32'(busy), 32'd1);
        send(8, 6'b110100);
        wait_done(2);

        // -32 then zeros: peak 32 -> gain 0.75, mean -2 -> +2
        push("zm32", 4'b1001, 4'b0010);
        do_start();
        send(1, 6'b100000);
        send(15, 6'd0);
        wait_done(3);

        // z_valid in IDLE ignored; start in COMPUTE ignored; z_valid in DONE ignored
        send(2, 6'b100000);
        check("idle_zvalid_busy", 32'(busy), 32'd0);
        push("z3", 4'b0011, 4'b0000);
        do_start();
        send(16, 6'd3);
        start = 1'b1;
        tick();
        start   = 1'b0;
        z_valid = 1'b1;
        z       = 6'b100000;
        tick();
        z_valid = 1'b0;
        wait_done(4);
        repeat (3) tick();
        check("start_in_compute_busy", 32'(busy), 32'd0);
        check("single_done", 32'(done_cnt), 32'd4);

        // Restart mid-window: the eight z=31 samples must be discarded
        push("restart", 4'b0011, 4'b0000);
        do_start();
        send(8, 6'd31);
        do_start();
        send(16, 6'd1);
        wait_done(5);

        // Reset mid-window: partial window dropped, outputs back to reset values
        do_start();
        send(10, 6'd7);
        reset = 1'b1;
        #1;
        check("midrst_factor", 32'(BN_factor), 32'b0100);
        check("midrst_addend", 32'(BN_addend), 32'd0);
        check("midrst_pvalid", 32'(params_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("midrst_no_done", 32'(done_cnt), 32'd5);
        check("midrst_idle", 32'(busy), 32'd0);

        // Recovery after reset: z=-4 -> gain 6, mean -4 -> +4
        push("zm4", 4'b1110, 4'b0100);
        do_start();
        send(16, 6'b111100);
        wait_done(6);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
